// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Reader end of the transmit FIFO. Pops one byte at a time from a show-ahead
// fifo and shifts it out as a start / DBIT data (LSB first) / stop frame on tx.
// A private divider produces the 16x oversampling tick; it is parked at zero
// while idle so that every frame starts on a fresh bit boundary.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // s_tick counter must reach 15 for data/start bits and SB_TICK-1 for stop
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DVSR_W-1:0] DIV_LAST  = DVSR_W'(DVSR - 1);
  localparam logic [S_W-1:0]    BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0]    STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_LAST    = N_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [DVSR_W-1:0] div_reg, div_next;
  logic [S_W-1:0]    s_reg, s_next;
  logic [N_W-1:0]    n_reg, n_next;
  logic [DBIT-1:0]   b_reg, b_next;
  logic [DBIT-1:0]   b_shift;
  logic              tx_reg, tx_next;
  logic              s_tick;
  logic              start_frame;

  // Oversampling tick fires on the last cycle of each divider period
  assign s_tick  = (div_reg == DIV_LAST);
  assign b_shift = b_reg >> 1;

  // A frame may begin only from IDLE with data available; reset blocks the pop
  // so the fifo is never drained while the block is being held in reset
  assign start_frame = (state_reg == IDLE) && tx_en && !fifo_empty && !reset;

  assign tx = tx_reg;

  // State and datapath registers; async reset returns the line to idle-high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: frame sequencing, bit counting and the baud divider
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = tx_reg;

    if (state_reg == IDLE || s_tick) begin
      div_next = '0;
    end else begin
      div_next = div_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (start_frame) begin
          state_next = START;
          b_next     = fifo_data;
          s_next     = '0;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = '0;
            b_next = b_shift;
            if (n_reg == N_LAST) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              n_next  = n_reg + 1'b1;
              tx_next = b_shift[0];
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            state_next = IDLE;
            s_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Outputs: pop strobe, busy flag and end-of-frame pulse
  always_comb begin
    fifo_rd      = start_frame;
    tx_busy      = (state_reg != IDLE);
    tx_done_tick = (state_reg == STOP) && s_tick && (s_reg == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader
// Drives uart_tx_fifo_reader from a show-ahead fifo model and checks every
// transmitted frame bit-by-bit against bytes queued when they were pushed.
module tb_uart_tx_fifo_reader;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR    = 2;
  localparam int DVSR_W  = 8;
  localparam int FRAME   = 320;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_count = 0;
  int done_count = 0;
  int last_rd_cyc = 0;
  int last_done_cyc = 0;
  int viol = 0;

  logic [7:0] exp_q [$];

  uart_tx_fifo_reader #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_W(DVSR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_en(tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Show-ahead fifo model
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  // Cycle counter and fifo pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  // Event monitor sampled just after the falling edge
  always begin
    @(negedge clk);
    #1;
    if (fifo_rd === 1'b1) begin
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (tx_done_tick === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (fifo_rd === 1'b1 && (tx_done_tick === 1'b1 || fifo_empty)) viol++;
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_sent);
    mem[wr_ptr[5:0]] = b;
    wr_ptr++;
    if (expect_sent) exp_q.push_back(b);
  endtask

  // Waits for the pop cycle, then records 320 cycles of line activity
  task automatic capture_frame(input logic [7:0] exp, output logic [7:0] got,
                               output int shape_err, output int c0, output bit ok);
    int   waited;
    int   bi;
    logic exp_tx;
    waited = 0;
    ok = 1'b0;
    shape_err = 0;
    got = '0;
    c0 = 0;
    #1;
    while (fifo_rd !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (fifo_rd !== 1'b1) return;
    ok = 1'b1;
    c0 = cyc;
    if (tx !== 1'b1 || tx_busy !== 1'b0) shape_err++;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      #1;
      if (k <= 32) exp_tx = 1'b0;
      else if (k <= 288) begin
        bi = (k - 33) / 32;
        exp_tx = exp[bi];
      end else exp_tx = 1'b1;
      if (tx !== exp_tx) shape_err++;
      if (tx_busy !== 1'b1) shape_err++;
      if (tx_done_tick !== (k == FRAME)) shape_err++;
      if (fifo_rd !== 1'b0) shape_err++;
      if (k >= 48 && k <= 272 && ((k - 48) % 32) == 0) begin
        bi = (k - 48) / 32;
        got[bi] = tx;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
    total++;
    if (fifo_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd: got %b expected 0", fifo_rd); end
    total++;
    if (tx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done_tick); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] e, got;
    int se, c0, rd0;
    bit ok;
    @(negedge clk);
    rd0 = rd_count;
    tx_en = 1'b1;
    push_byte(8'hA5, 1'b1);
    e = exp_q.pop_front();
    capture_frame(e, got, se, c0, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_start: got no fifo_rd expected fifo_rd"); end
    total++;
    if (got !== e) begin bad++; $display("[TB] FAIL single_data: got %h expected %h", got, e); end
    total++;
    if (se != 0) begin bad++; $display("[TB] FAIL single_shape: got %0d bad samples expected 0", se); end
    @(negedge clk);
    #2;
    total++;
    if (last_done_cyc - c0 != FRAME) begin
      bad++; $display("[TB] FAIL single_done_delay: got %0d expected %0d", last_done_cyc - c0, FRAME);
    end
    total++;
    if (rd_count - rd0 != 1) begin bad++; $display("[TB] FAIL single_pops: got %0d expected 1", rd_count - rd0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ea, eb, ga, gb;
    int sa, sb, ca, cb, rd0;
    bit oka, okb;
    @(negedge clk);
    rd0 = rd_count;
    push_byte(8'h55, 1'b1);
    push_byte(8'h0F, 1'b1);
    ea = exp_q.pop_front();
    capture_frame(ea, ga, sa, ca, oka);
    eb = exp_q.pop_front();
    capture_frame(eb, gb, sb, cb, okb);
    total++;
    if (!oka || !okb) begin bad++; $display("[TB] FAIL b2b_start: got %b%b expected 11", oka, okb); end
    total++;
    if (ga !== ea) begin bad++; $display("[TB] FAIL b2b_data0: got %h expected %h", ga, ea); end
    total++;
    if (gb !== eb) begin bad++; $display("[TB] FAIL b2b_data1: got %h expected %h", gb, eb); end
    total++;
    if (sa != 0 || sb != 0) begin bad++; $display("[TB] FAIL b2b_shape: got %0d/%0d expected 0/0", sa, sb); end
    total++;
    if (cb - ca != FRAME + 1) begin bad++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", cb - ca, FRAME + 1); end
    @(negedge clk);
    #2;
    total++;
    if (rd_count - rd0 != 2) begin bad++; $display("[TB] FAIL b2b_pops: got %0d expected 2", rd_count - rd0); end
  endtask

  task automatic test_tx_en_gate;
    logic [7:0] e, got;
    int se, c0, errs;
    bit ok;
    errs = 0;
    @(negedge clk);
    tx_en = 1'b0;
    push_byte(8'h12, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL gate_hold: got %0d bad cycles expected 0", errs); end
    @(negedge clk);
    tx_en = 1'b1;
    #1;
    total++;
    if (fifo_rd !== 1'b1) begin bad++; $display("[TB] FAIL gate_rd_same_cycle: got %b expected 1", fifo_rd); end
    e = exp_q.pop_front();
    capture_frame(e, got, se, c0, ok);
    total++;
    if (!ok || got !== e) begin bad++; $display("[TB] FAIL gate_data: got %h expected %h", got, e); end
    total++;
    if (se != 0) begin bad++; $display("[TB] FAIL gate_shape: got %0d expected 0", se); end
  endtask

  task automatic test_empty_wait;
    logic [7:0] e, got;
    int se, c0, errs;
    bit ok;
    errs = 0;
    @(negedge clk);
    tx_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL empty_hold: got %0d bad cycles expected 0", errs); end
    @(negedge clk);
    push_byte(8'h6B, 1'b1);
    #1;
    total++;
    if (fifo_rd !== 1'b1) begin bad++; $display("[TB] FAIL empty_rd_on_push: got %b expected 1", fifo_rd); end
    e = exp_q.pop_front();
    capture_frame(e, got, se, c0, ok);
    total++;
    if (!ok || got !== e) begin bad++; $display("[TB] FAIL empty_data: got %h expected %h", got, e); end
    total++;
    if (se != 0) begin bad++; $display("[TB] FAIL empty_shape: got %0d expected 0", se); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] e, got;
    int se, c0, w, rd_snap, done_snap;
    bit ok;
    @(negedge clk);
    tx_en = 1'b1;
    push_byte(8'hFF, 1'b1);
    push_byte(8'h81, 1'b1);
    #1;
    w = 0;
    while (fifo_rd !== 1'b1 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    total++;
    if (fifo_rd !== 1'b1) begin bad++; $display("[TB] FAIL rst_start: got %b expected 1", fifo_rd); end
    repeat (140) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("[TB] FAIL rst_tx_immediate: got %b expected 1", tx); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_immediate: got %b expected 0", tx_busy); end
    #1;
    rd_snap = rd_count;
    done_snap = done_count;
    repeat (5) @(negedge clk);
    #2;
    total++;
    if (rd_count != rd_snap) begin bad++; $display("[TB] FAIL rst_no_pop: got %0d expected %0d", rd_count, rd_snap); end
    total++;
    if (done_count != done_snap) begin bad++; $display("[TB] FAIL rst_no_done: got %0d expected %0d", done_count, done_snap); end
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    e = exp_q.pop_front();
    capture_frame(e, got, se, c0, ok);
    total++;
    if (!ok || got !== e) begin bad++; $display("[TB] FAIL rst_next_data: got %h expected %h", got, e); end
    total++;
    if (se != 0) begin bad++; $display("[TB] FAIL rst_next_shape: got %0d expected 0", se); end
  endtask

  task automatic test_tx_en_drop;
    logic [7:0] e, got;
    int se, c0, rd0;
    bit ok;
    @(negedge clk);
    rd0 = rd_count;
    tx_en = 1'b1;
    push_byte(8'h3C, 1'b1);
    push_byte(8'h99, 1'b0);
    e = exp_q.pop_front();
    fork
      capture_frame(e, got, se, c0, ok);
      begin
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    total++;
    if (!ok || got !== e) begin bad++; $display("[TB] FAIL drop_data: got %h expected %h", got, e); end
    total++;
    if (se != 0) begin bad++; $display("[TB] FAIL drop_shape: got %0d expected 0", se); end
    repeat (400) @(negedge clk);
    #2;
    total++;
    if (rd_count - rd0 != 1) begin bad++; $display("[TB] FAIL drop_pops: got %0d expected 1", rd_count - rd0); end
    total++;
    if (wr_ptr - rd_ptr != 1) begin bad++; $display("[TB] FAIL drop_fifo_level: got %0d expected 1", wr_ptr - rd_ptr); end
    total++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("[TB] FAIL drop_idle: got busy=%b tx=%b expected 0/1", tx_busy, tx); end
  endtask

  task automatic test_invariants;
    total++;
    if (viol != 0) begin bad++; $display("[TB] FAIL rd_overlap: got %0d expected 0", viol); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_en_gate();
    test_empty_wait();
    test_reset_mid_frame();
    test_tx_en_drop();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
